// File: rtl/ram_512x8.sv
// ram_512x8: 512x8 big-endian byte memory with an MFA/MFC handshake.
// Define RAM_ALIGN_CHECK_EN to add the Misaligned output and suppress misaligned accesses.
module ram_512x8 #(
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        MFA,
  input  logic        ReadWrite,
  input  logic [5:0]  S,
  input  logic [8:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC
`ifdef RAM_ALIGN_CHECK_EN
  ,
  output logic        Misaligned
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic        rd;
    logic        sx;
    logic [1:0]  size;
    logic [8:0]  addr;
    logic [31:0] data;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic        mfc_nx;
  req_t        req;
  logic [31:0] ld_val;

  logic [7:0]  mem [512];

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [8:0]  a0;
  logic [8:0]  a1;
  logic [8:0]  a2;
  logic [8:0]  a3;
  logic [7:0]  b0;
  logic [7:0]  b1;
  logic [7:0]  b2;
  logic [7:0]  b3;
  logic        fire;
  logic        align_bad;
  logic        do_rd;
  logic        do_wr;

  // S[2] and S[5:4] carry nothing this memory needs.
  logic        unused_op3;
  assign unused_op3 = ^{S[5:4], S[2]};

  // Doubleword (11) falls through to a plain word transfer.
  assign is_b = (req.size == 2'b01);
  assign is_h = (req.size == 2'b10);
  assign is_w = !is_b && !is_h;

  // Byte lanes wrap modulo 512 through natural 9-bit overflow.
  assign a0 = req.addr;
  assign a1 = req.addr + 9'd1;
  assign a2 = req.addr + 9'd2;
  assign a3 = req.addr + 9'd3;

  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

`ifdef RAM_ALIGN_CHECK_EN
  assign align_bad = (is_h && a0[0])
                   || (is_w && (a0[1:0] != 2'b00));
`else
  assign align_bad = 1'b0;
`endif

  // The access happens only on the edge the counter expires with MFA still up.
  assign fire  = (state == BUSY) && MFA && (cnt == 4'd0);
  assign do_rd = fire && req.rd && !align_bad;
  assign do_wr = fire && !req.rd && !align_bad;

  // Load formatting: right-justify and optionally sign-extend.
  always_comb begin
    ld_val = '0;
    unique case (1'b1)
      is_b: ld_val = {{24{req.sx & b0[7]}}, b0};
      is_h: ld_val = {{16{req.sx & b0[7]}}, b0, b1};
      is_w: ld_val = {b0, b1, b2, b3};
      default: ld_val = '0;
    endcase
  end

  // Handshake sequencing: next state, counter and MFC.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mfc_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (MFA) begin
          state_nx = BUSY;
          cnt_nx   = CNT_INIT;
        end
      end
      BUSY: begin
        if (!MFA) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx = DONE;
          mfc_nx   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      DONE: begin
        if (MFA) begin
          mfc_nx = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state, request capture and load result.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      cnt     <= '0;
      MFC     <= 1'b0;
      DataOut <= '0;
      req     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      MFC   <= mfc_nx;
      if (state == IDLE && MFA) begin
        req.rd   <= ReadWrite;
        req.sx   <= S[3];
        req.size <= S[1:0];
        req.addr <= Address;
        req.data <= DataIn;
      end
      if (do_rd) begin
        DataOut <= ld_val;
      end
    end
  end

`ifdef RAM_ALIGN_CHECK_EN
  logic mis_nx;

  // Misaligned flag tracks MFC for a rejected access.
  always_comb begin
    mis_nx = 1'b0;
    if (fire) begin
      mis_nx = align_bad;
    end else if (state == DONE && MFA) begin
      mis_nx = Misaligned;
    end
  end

  // Misaligned flag register.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      Misaligned <= 1'b0;
    end else begin
      Misaligned <= mis_nx;
    end
  end
`endif

  // Store path; the array itself is never cleared.
  always_ff @(posedge Clk) begin
    if (do_wr) begin
      unique case (1'b1)
        is_b: begin
          mem[a0] <= req.data[7:0];
        end
        is_h: begin
          mem[a0] <= req.data[15:8];
          mem[a1] <= req.data[7:0];
        end
        is_w: begin
          mem[a0] <= req.data[31:24];
          mem[a1] <= req.data[23:16];
          mem[a2] <= req.data[15:8];
          mem[a3] <= req.data[7:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_512x8.sv
// tb_ram_512x8: directed table-driven bench for ram_512x8.
// Runs with LATENCY=3; RAM_ALIGN_CHECK_EN adds the Misaligned test.
module tb_ram_512x8;

  localparam int LAT = 3;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        MFA;
  logic        ReadWrite;
  logic [5:0]  S;
  logic [8:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;
`ifdef RAM_ALIGN_CHECK_EN
  logic        Misaligned;
  logic        mis_at_mfc;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          rw;
    logic [5:0]  s;
    logic [8:0]  a;
    logic [31:0] din;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  ram_512x8 #(.LATENCY(LAT)) dut (
    .Clk(Clk),
    .Clr(Clr),
    .MFA(MFA),
    .ReadWrite(ReadWrite),
    .S(S),
    .Address(Address),
    .DataIn(DataIn),
    .DataOut(DataOut),
    .MFC(MFC)
`ifdef RAM_ALIGN_CHECK_EN
    ,
    .Misaligned(Misaligned)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One complete request: accept, scramble inputs, wait MFC, hold, release.
  task automatic access(input bit rw,
                        input logic [5:0] s,
                        input logic [8:0] a,
                        input logic [31:0] din,
                        input string nm,
                        output logic [31:0] dout);
    int edges;
    @(negedge Clk);
    MFA = 1'b1;
    ReadWrite = rw;
    S = s;
    Address = a;
    DataIn = din;
    @(posedge Clk);
    #1;
    ReadWrite = ~rw;
    S = 6'b000101;
    Address = ~a;
    DataIn = ~din;
    edges = 0;
    while (MFC !== 1'b1 && edges < 40) begin
      @(posedge Clk);
      #1;
      edges++;
    end
    chk({nm, "_lat"}, edges, LAT);
    dout = DataOut;
`ifdef RAM_ALIGN_CHECK_EN
    mis_at_mfc = Misaligned;
`endif
    @(posedge Clk);
    #1;
    chk({nm, "_hold"}, {31'd0, MFC}, 32'd1);
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk);
    #1;
    chk({nm, "_fall"}, {31'd0, MFC}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    bit seen;

    vecs.push_back('{1'b0, 6'b000100, 9'h010, 32'hDEADBEEF,
                     32'h00000000, "stw"});
    vecs.push_back('{1'b1, 6'b000000, 9'h010, 32'h0,
                     32'hDEADBEEF, "ldw"});
    vecs.push_back('{1'b1, 6'b000001, 9'h011, 32'h0,
                     32'h000000AD, "ldub"});
    vecs.push_back('{1'b1, 6'b001001, 9'h011, 32'h0,
                     32'hFFFFFFAD, "ldsb"});
    vecs.push_back('{1'b1, 6'b001010, 9'h012, 32'h0,
                     32'hFFFFBEEF, "ldsh"});
    vecs.push_back('{1'b1, 6'b000010, 9'h012, 32'h0,
                     32'h0000BEEF, "lduh"});
    vecs.push_back('{1'b0, 6'b000101, 9'h013, 32'h12345677,
                     32'h0000BEEF, "stb"});
    vecs.push_back('{1'b1, 6'b000000, 9'h010, 32'h0,
                     32'hDEADBE77, "ldw_stb"});
    vecs.push_back('{1'b0, 6'b000110, 9'h010, 32'h0000CAFE,
                     32'hDEADBE77, "sth"});
    vecs.push_back('{1'b1, 6'b000000, 9'h010, 32'h0,
                     32'hCAFEBE77, "ldw_sth"});
    vecs.push_back('{1'b1, 6'b000011, 9'h010, 32'h0,
                     32'hCAFEBE77, "ldd"});
`ifndef RAM_ALIGN_CHECK_EN
    vecs.push_back('{1'b0, 6'b000100, 9'h1FE, 32'h11223344,
                     32'hCAFEBE77, "stw_wrap"});
    vecs.push_back('{1'b1, 6'b000001, 9'h1FE, 32'h0,
                     32'h00000011, "wrap_b0"});
    vecs.push_back('{1'b1, 6'b000001, 9'h1FF, 32'h0,
                     32'h00000022, "wrap_b1"});
    vecs.push_back('{1'b1, 6'b000001, 9'h000, 32'h0,
                     32'h00000033, "wrap_b2"});
    vecs.push_back('{1'b1, 6'b000001, 9'h001, 32'h0,
                     32'h00000044, "wrap_b3"});
    vecs.push_back('{1'b1, 6'b000000, 9'h1FE, 32'h0,
                     32'h11223344, "ldw_wrap"});
`endif
    vecs.push_back('{1'b1, 6'b001010, 9'h010, 32'h0,
                     32'hFFFFCAFE, "ldsh_neg"});
    vecs.push_back('{1'b1, 6'b001001, 9'h013, 32'h0,
                     32'h00000077, "ldsb_pos"});

    Clr = 1'b0;
    MFA = 1'b0;
    ReadWrite = 1'b1;
    S = '0;
    Address = '0;
    DataIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_mfc", {31'd0, MFC}, 32'd0);
    chk("rst_dout", DataOut, 32'd0);
    @(negedge Clk);
    Clr = 1'b1;

    foreach (vecs[i]) begin
      access(vecs[i].rw, vecs[i].s, vecs[i].a,
             vecs[i].din, vecs[i].nm, d);
      chk({vecs[i].nm, "_data"}, d, vecs[i].exp);
    end

`ifdef RAM_ALIGN_CHECK_EN
    access(1'b1, 6'b000000, 9'h002, 32'h0, "mis_ldw", d);
    chk("mis_ldw_data", d, 32'h00000077);
    chk("mis_flag", {31'd0, mis_at_mfc}, 32'd1);
`endif

    // Reset in the middle of a store: no write, outputs clear at once.
    @(negedge Clk);
    MFA = 1'b1;
    ReadWrite = 1'b0;
    S = 6'b000100;
    Address = 9'h010;
    DataIn = 32'hFFFFFFFF;
    @(posedge Clk);
    #3;
    Clr = 1'b0;
    #1;
    chk("midrst_mfc", {31'd0, MFC}, 32'd0);
    chk("midrst_dout", DataOut, 32'd0);
    MFA = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    access(1'b1, 6'b000000, 9'h010, 32'h0, "post_rst", d);
    chk("post_rst_data", d, 32'hCAFEBE77);

    // Abort: MFA dropped after acceptance suppresses the store.
    access(1'b0, 6'b000100, 9'h040, 32'h0BADF00D, "st40", d);
    @(negedge Clk);
    MFA = 1'b1;
    ReadWrite = 1'b0;
    S = 6'b000100;
    Address = 9'h040;
    DataIn = 32'h99999999;
    @(posedge Clk);
    @(negedge Clk);
    MFA = 1'b0;
    seen = 1'b0;
    repeat (LAT + 3) begin
      @(posedge Clk);
      #1;
      if (MFC === 1'b1) seen = 1'b1;
    end
    chk("abort_mfc", {31'd0, seen}, 32'd0);
    access(1'b1, 6'b000000, 9'h040, 32'h0, "abort_ld", d);
    chk("abort_data", d, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_512x8.md
Name: ram_512x8

Overview:
- Byte-addressable 512x8 big-endian data/instruction memory for the SPARC datapath.
- Serves word, halfword and byte loads (signed/unsigned) and stores through an MFA/MFC request/complete handshake.
- Access type comes from the SPARC op3 field (IR[24:19]); instruction fetch drives op3 = 000000 (word load).
- Sits between MAR/MDR and the IR/MDR input muxes.

Parameters:
- LATENCY, 2, clock cycles from MFA acceptance to MFC assertion; legal range 1..15.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Clr  input  1  asynchronous active-low reset.
- MFA  input  1  memory function active (request); held high until MFC is seen.
- ReadWrite  input  1  1 = read (load), 0 = write (store).
- S  input  6  op3 access code.
- Address  input  9  byte address of the first (most significant) byte.
- DataIn  input  32  store data, right-justified.
- DataOut  output  32  load result.
- MFC  output  1  memory function complete.

Behaviour:
- Reset (Clr=0, asynchronous): MFC=0, DataOut=0, FSM to IDLE, latency counter=0. Memory array contents are not cleared.
- Access decode from S:
  - size = S[1:0]: 00 word, 01 byte, 10 halfword, 11 doubleword (treated as word; no 64-bit transfer).
  - S[3]=1 selects sign extension for byte/halfword loads.
  - S[2] and S[5:4] are ignored; direction comes only from ReadWrite.
- FSM IDLE -> BUSY -> DONE -> IDLE:
  - IDLE: on a rising edge with MFA=1, latch S, ReadWrite, Address, DataIn; load counter=LATENCY-1; go to BUSY.
  - BUSY: decrement the counter each edge. On the edge where it reads 0, perform the access, set MFC=1, go to DONE. With LATENCY=1, MFC rises on the edge after acceptance.
  - DONE: MFC stays 1 while MFA=1. On the first edge with MFA=0, MFC=0 and go to IDLE. A new request requires MFA low for at least one edge.
  - MFA dropping during BUSY aborts: no access, MFC stays 0, return to IDLE.
- Loads (big-endian, A = latched address):
  - Word: DataOut={m[A],m[A+1],m[A+2],m[A+3]}.
  - Halfword: DataOut[15:0]={m[A],m[A+1]}; upper 16 bits zero, or copies of bit 15 when S[3]=1.
  - Byte: DataOut[7:0]=m[A]; upper 24 bits zero, or copies of bit 7 when S[3]=1.
- Stores:
  - Word: m[A..A+3]=DataIn[31:24],[23:16],[15:8],[7:0].
  - Halfword: m[A]=DataIn[15:8], m[A+1]=DataIn[7:0].
  - Byte: m[A]=DataIn[7:0].
  - DataOut is unchanged by stores.
- Address arithmetic is modulo 512: A+k wraps (a word at 0x1FE touches 0x1FE, 0x1FF, 0x000, 0x001).
- Alignment is not enforced unless the optional feature is enabled.
- Inputs changing after acceptance have no effect on the access in progress.
- DataOut holds the last load value until the next load completes or reset.
- Reset mid-operation aborts the access: no partial write, MFC=0.

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined:
  - Adds output Misaligned (1 bit).
  - At completion, if a halfword has A[0]!=0, or a word/doubleword has A[1:0]!=0, no memory write occurs and DataOut is unchanged.
  - MFC still asserts, and Misaligned=1 for the same cycles as MFC.
  - Misaligned resets to 0.
- Undefined: no Misaligned port; misaligned accesses proceed with wrap-around addressing as above.

Test Plan:
- Reset with Clr=0 mid-BUSY -> MFC=0, DataOut=0 immediately; the subsequent request completes normally.
- Store word S=000100, A=0x010, DataIn=0xDEADBEEF; then load word S=000000 -> DataOut=0xDEADBEEF; MFC high exactly LATENCY edges after MFA is sampled; MFC falls the edge after MFA drops.
- After the word store: LDUB S=000001 A=0x011 -> 0x000000AD; LDSB S=001001 A=0x011 -> 0xFFFFFFAD; LDSH S=001010 A=0x012 -> 0xFFFFBEEF; LDUH S=000010 A=0x012 -> 0x0000BEEF.
- STB S=000101 A=0x013 DataIn=0x12345677 -> the following word load at 0x010 returns 0xDEADBE77; STH S=000110 A=0x010 DataIn=0x0000CAFE -> 0xCAFEBE77.
- Word store 0x11223344 at A=0x1FE -> bytes 0x1FE=0x11, 0x1FF=0x22, 0x000=0x33, 0x001=0x44; word load at 0x1FE returns 0x11223344.
- MFA dropped after one cycle with LATENCY=3 on a store -> MFC never asserts; memory unchanged. With RAM_ALIGN_CHECK_EN, a word load at 0x002 -> Misaligned=1 with MFC, DataOut unchanged.
